// File: rtl/bus_rx_flow_pkg.sv
// ---------------------------------------------------------------------------
// bus_rx_flow_pkg
// Shared I3C controller receive-path definitions: receive FSM state encoding,
// bits-per-byte constant, bit counter reload value and the MSB-first shift
// helper used by the receive flow.
// ---------------------------------------------------------------------------
package bus_rx_flow_pkg;

  localparam int BitsPerByte = 8;

  // Bit counter counts down from the MSB index to 0.
  localparam logic [2:0] CntLoad = 3'(BitsPerByte - 1);

  typedef enum logic [1:0] {
    RX_IDLE      = 2'd0,
    RX_READ_BYTE = 2'd1,
    RX_READ_BIT  = 2'd2,
    RX_NEXT_TASK = 2'd3
  } rx_state_e;

  // Shift one new bit in at the LSB end; the first bit received ends up in [7].
  function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
    return {sr[6:0], b};
  endfunction

endpackage

// File: rtl/bus_rx_flow_bus_rx.sv
// ---------------------------------------------------------------------------
// bus_rx
// Edge-qualified SDA sampler with optional SDA stability checker.
//
// Optional feature macro: I3C_RX_SDA_STABLE_CHECK_EN
//   defined   : the level taken at an accepted SCL rising edge is compared
//               with sda each following cycle until the SCL falling edge;
//               a difference raises stab_err for one cycle.
//   undefined : stab_err is tied low and no compare logic exists.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   scl_posedge     : one-cycle pulse on SCL rising edge
//   scl_negedge     : one-cycle pulse on SCL falling edge
//   sda             : synchronized SDA level
//   enable          : receive FSM is willing to accept a sample this cycle
//   sample_valid    : a bit is sampled this cycle
//   sample_bit      : the sampled bit value
//   stab_err        : SDA moved while SCL was high (combinational)
// ---------------------------------------------------------------------------
module bus_rx (
  input  logic clk,
  input  logic rst,
  input  logic scl_posedge,
  input  logic scl_negedge,
  input  logic sda,
  input  logic enable,
  output logic sample_valid,
  output logic sample_bit,
  output logic stab_err
);

  assign sample_valid = scl_posedge & enable;
  assign sample_bit   = sda;

`ifdef I3C_RX_SDA_STABLE_CHECK_EN
  logic armed_r;
  logic level_r;

  // A new rising edge starts a fresh bit, so the compare is skipped in that
  // cycle; the falling edge cycle is also excluded because SDA may move there.
  assign stab_err = armed_r & ~scl_posedge & ~scl_negedge & (sda != level_r);

  // Capture the sampled level and keep the checker armed while SCL is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_r <= 1'b0;
      level_r <= 1'b0;
    end else if (sample_valid) begin
      armed_r <= 1'b1;
      level_r <= sda;
    end else if (scl_negedge || stab_err) begin
      armed_r <= 1'b0;
      level_r <= level_r;
    end else begin
      armed_r <= armed_r;
      level_r <= level_r;
    end
  end
`else
  logic unused_s;

  assign stab_err = 1'b0;
  assign unused_s = ^{clk, rst, scl_negedge};
`endif

endmodule

// File: rtl/bus_rx_flow.sv
// ---------------------------------------------------------------------------
// bus_rx_flow
// I3C receive flow: receives a byte (MSB first) or a single bit (T-bit or
// ACK/NACK) on request, sampling SDA on accepted SCL rising edges.
//
// Optional feature macro: I3C_RX_SDA_STABLE_CHECK_EN (SDA stability check,
// reported on bus_error_o; tied low when undefined).
//
// Ports
//   clk_i          : clock
//   rst_i          : asynchronous active-high reset
//   scl_posedge_i  : one-cycle pulse per SCL rising edge
//   scl_negedge_i  : one-cycle pulse per SCL falling edge
//   sda_i          : synchronized SDA level
//   req_byte_i     : request to receive 8 bits
//   req_bit_i      : request to receive 1 bit
//   rx_data_o      : last received byte / bit (bit in [0])
//   rx_done_o      : one-cycle pulse, rx_data_o valid from this cycle
//   rx_idle_o      : FSM is in Idle
//   req_error_o    : both requests high (combinational)
//   bus_error_o    : one-cycle pulse when SDA changed while SCL high
// ---------------------------------------------------------------------------
module bus_rx_flow
  import bus_rx_flow_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_posedge_i,
  input  logic       scl_negedge_i,
  input  logic       sda_i,
  input  logic       req_byte_i,
  input  logic       req_bit_i,
  output logic [7:0] rx_data_o,
  output logic       rx_done_o,
  output logic       rx_idle_o,
  output logic       req_error_o,
  output logic       bus_error_o
);

  rx_state_e  state_r, state_next_s;
  logic [2:0] cnt_r, cnt_next_s;
  logic [7:0] shift_r, shift_next_s;
  logic [7:0] rx_data_r, rx_data_next_s;
  logic       rx_done_r, rx_done_next_s;
  logic       idle_r;
  logic       req_err_s;
  logic       enable_s;
  logic       sample_valid_s;
  logic       sample_bit_s;
  logic       stab_err_s;

  assign req_err_s   = req_byte_i & req_bit_i;
  assign req_error_o = req_err_s;

  // Samples are accepted only while exactly one request is up and it matches
  // the transfer in progress; Idle/NextTaskDecision accept on the first
  // request cycle so no edge is lost between transfers.
  assign enable_s = (req_byte_i ^ req_bit_i) &
                    ((state_r == RX_IDLE) | (state_r == RX_NEXT_TASK) |
                     ((state_r == RX_READ_BYTE) & req_byte_i) |
                     ((state_r == RX_READ_BIT)  & req_bit_i));

  bus_rx u_bus_rx (
    .clk          (clk_i),
    .rst          (rst_i),
    .scl_posedge  (scl_posedge_i),
    .scl_negedge  (scl_negedge_i),
    .sda          (sda_i),
    .enable       (enable_s),
    .sample_valid (sample_valid_s),
    .sample_bit   (sample_bit_s),
    .stab_err     (stab_err_s)
  );

  // Next-state, shift/counter and output-data decisions of the receive FSM.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    shift_next_s   = shift_r;
    rx_data_next_s = rx_data_r;
    rx_done_next_s = 1'b0;
    case (state_r)
      RX_IDLE, RX_NEXT_TASK: begin
        cnt_next_s   = CntLoad;
        shift_next_s = 8'h00;
        if (req_err_s || stab_err_s) begin
          state_next_s = RX_IDLE;
        end else if (req_byte_i) begin
          state_next_s = RX_READ_BYTE;
          if (sample_valid_s) begin
            shift_next_s = shift_in(8'h00, sample_bit_s);
            cnt_next_s   = CntLoad - 3'd1;
          end else begin
            shift_next_s = 8'h00;
          end
        end else if (req_bit_i) begin
          if (sample_valid_s) begin
            state_next_s   = RX_NEXT_TASK;
            rx_data_next_s = {7'b0000000, sample_bit_s};
            rx_done_next_s = 1'b1;
          end else begin
            state_next_s = RX_READ_BIT;
          end
        end else begin
          state_next_s = RX_IDLE;
        end
      end
      RX_READ_BYTE: begin
        if (req_err_s || !req_byte_i || stab_err_s) begin
          // Abort: discard the partial byte, keep the last delivered data.
          state_next_s = RX_IDLE;
          cnt_next_s   = CntLoad;
          shift_next_s = 8'h00;
        end else if (sample_valid_s) begin
          if (cnt_r == 3'd0) begin
            state_next_s   = RX_NEXT_TASK;
            rx_data_next_s = shift_in(shift_r, sample_bit_s);
            rx_done_next_s = 1'b1;
            cnt_next_s     = CntLoad;
            shift_next_s   = 8'h00;
          end else begin
            shift_next_s = shift_in(shift_r, sample_bit_s);
            cnt_next_s   = cnt_r - 3'd1;
          end
        end else begin
          state_next_s = RX_READ_BYTE;
        end
      end
      RX_READ_BIT: begin
        if (req_err_s || !req_bit_i || stab_err_s) begin
          state_next_s = RX_IDLE;
        end else if (sample_valid_s) begin
          state_next_s   = RX_NEXT_TASK;
          rx_data_next_s = {7'b0000000, sample_bit_s};
          rx_done_next_s = 1'b1;
        end else begin
          state_next_s = RX_READ_BIT;
        end
      end
      default: begin
        state_next_s = RX_IDLE;
        cnt_next_s   = CntLoad;
        shift_next_s = 8'h00;
      end
    endcase
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= RX_IDLE;
      cnt_r     <= CntLoad;
      shift_r   <= 8'h00;
      rx_data_r <= 8'h00;
      rx_done_r <= 1'b0;
      idle_r    <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      shift_r   <= shift_next_s;
      rx_data_r <= rx_data_next_s;
      rx_done_r <= rx_done_next_s;
      idle_r    <= (state_next_s == RX_IDLE);
    end
  end

`ifdef I3C_RX_SDA_STABLE_CHECK_EN
  logic bus_error_r;

  // One-cycle bus error pulse following a detected SDA instability.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_error_r <= 1'b0;
    end else begin
      bus_error_r <= stab_err_s;
    end
  end

  assign bus_error_o = bus_error_r;
`else
  assign bus_error_o = 1'b0;
`endif

  assign rx_data_o = rx_data_r;
  assign rx_done_o = rx_done_r;
  assign rx_idle_o = idle_r;

endmodule

// File: tb/tb_bus_rx_flow.sv
// ---------------------------------------------------------------------------
// tb_bus_rx_flow
// Directed plus randomized bench for bus_rx_flow. Expected bytes, done pulse
// counts and bus error counts come from a transfer-level model kept here.
// ---------------------------------------------------------------------------
module tb_bus_rx_flow;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_pos;
  logic       scl_neg;
  logic       sda;
  logic       req_byte;
  logic       req_bit;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_idle;
  logic       req_error;
  logic       bus_error;

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;
  int err_seen    = 0;
  int done_exp    = 0;
  int err_exp     = 0;
  logic [7:0] exp_data = 8'h00;

  bus_rx_flow dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .scl_posedge_i (scl_pos),
    .scl_negedge_i (scl_neg),
    .sda_i         (sda),
    .req_byte_i    (req_byte),
    .req_bit_i     (req_bit),
    .rx_data_o     (rx_data),
    .rx_done_o     (rx_done),
    .rx_idle_o     (rx_idle),
    .req_error_o   (req_error),
    .bus_error_o   (bus_error)
  );

  always #5 clk = ~clk;

  // Count output pulses away from the active edge.
  always @(negedge clk) begin
    if (rx_done === 1'b1) done_seen++;
    if (bus_error === 1'b1) err_seen++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full SCL bit period; optionally flip SDA while SCL is high.
  task automatic clock_bit(input logic b, input bit toggle);
    sda = b;
    scl_pos = 1'b1; cyc(); scl_pos = 1'b0;
    cyc();
    if (toggle) sda = ~b;
    cyc();
    scl_neg = 1'b1; cyc(); scl_neg = 1'b0;
    cyc();
  endtask

  // Complete transfer; the request goes up with the first rising edge. With
  // drop=0 it returns in the done cycle so the next transfer starts right away.
  task automatic xfer(input bit is_byte, input logic [7:0] val, input bit drop);
    int n;
    logic [7:0] want;
    n = is_byte ? 8 : 1;
    want = is_byte ? val : {7'b0000000, val[0]};
    req_byte = is_byte;
    req_bit  = !is_byte;
    for (int i = 0; i < n; i++) begin
      sda = is_byte ? val[7-i] : val[0];
      scl_pos = 1'b1; cyc(); scl_pos = 1'b0;
      if (i == n - 1) begin
        check("done_after_last_edge", {31'd0, rx_done}, 32'd1);
        check("data_at_done", {24'd0, rx_data}, {24'd0, want});
        exp_data = want;
        done_exp++;
        if (drop) begin
          req_byte = 1'b0;
          req_bit  = 1'b0;
          cyc();
          check("done_one_cycle", {31'd0, rx_done}, 32'd0);
          check("data_holds", {24'd0, rx_data}, {24'd0, exp_data});
          cyc();
          scl_neg = 1'b1; cyc(); scl_neg = 1'b0;
          cyc();
        end
      end else begin
        check("no_partial_data", {24'd0, rx_data}, {24'd0, exp_data});
        cyc(); cyc();
        scl_neg = 1'b1; cyc(); scl_neg = 1'b0;
        cyc();
      end
    end
  endtask

  initial begin
    bit         rb;
    bit         rd;
    logic [7:0] rv;

    rst = 1'b1; scl_pos = 1'b0; scl_neg = 1'b0; sda = 1'b1;
    req_byte = 1'b0; req_bit = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    check("reset_data", {24'd0, rx_data}, 32'd0);
    check("reset_done", {31'd0, rx_done}, 32'd0);
    check("reset_idle", {31'd0, rx_idle}, 32'd1);
    check("reset_bus_error", {31'd0, bus_error}, 32'd0);
    check("reset_req_error", {31'd0, req_error}, 32'd0);

    // Byte 0xA5 with the request arriving on the first rising edge.
    xfer(1'b1, 8'hA5, 1'b1);
    check("idle_after_a5", {31'd0, rx_idle}, 32'd1);

    // Bit 0, then a byte 0x3C starting in the NextTaskDecision cycle.
    rx_data_probe: begin
      xfer(1'b0, 8'h00, 1'b0);
      xfer(1'b1, 8'h3C, 1'b1);
    end
    check("done_count_b2b", done_seen, done_exp);

    // Abort after 4 edges, then 0xFF.
    req_byte = 1'b1;
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), 1'b0);
    req_byte = 1'b0;
    cyc();
    check("abort_idle", {31'd0, rx_idle}, 32'd1);
    check("abort_data_kept", {24'd0, rx_data}, {24'd0, exp_data});
    check("abort_no_done", done_seen, done_exp);
    xfer(1'b1, 8'hFF, 1'b1);

    // Both requests: request error, stay Idle, no sampling.
    req_byte = 1'b1; req_bit = 1'b1;
    #1;
    check("req_error_high", {31'd0, req_error}, 32'd1);
    clock_bit(1'b0, 1'b0);
    clock_bit(1'b1, 1'b0);
    check("req_error_idle", {31'd0, rx_idle}, 32'd1);
    check("req_error_no_done", done_seen, done_exp);
    check("req_error_data", {24'd0, rx_data}, {24'd0, exp_data});
    req_byte = 1'b0; req_bit = 1'b0;
    cyc();

    // Asynchronous reset after 5 edges, then 0x81.
    req_byte = 1'b1;
    for (int i = 0; i < 5; i++) clock_bit(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    exp_data = 8'h00;
    check("async_rst_data", {24'd0, rx_data}, 32'd0);
    check("async_rst_done", {31'd0, rx_done}, 32'd0);
    check("async_rst_idle", {31'd0, rx_idle}, 32'd1);
    check("async_rst_bus_error", {31'd0, bus_error}, 32'd0);
    req_byte = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    xfer(1'b1, 8'h81, 1'b1);
    check("done_count_rst", done_seen, done_exp);

    // Randomized back-to-back and separated transfers.
    for (int k = 0; k < 12; k++) begin
      rb = 1'($urandom_range(0, 1));
      rd = (k == 11) ? 1'b1 : 1'($urandom_range(0, 1));
      rv = 8'($urandom);
      xfer(rb, rv, rd);
    end
    cyc();
    check("done_count_random", done_seen, done_exp);
    check("idle_after_random", {31'd0, rx_idle}, 32'd1);

    // SDA moves while SCL is high during bit 3.
    rv = 8'($urandom);
    req_byte = 1'b1;
    for (int i = 0; i < 4; i++) clock_bit(rv[7-i], 1'b0);
`ifdef I3C_RX_SDA_STABLE_CHECK_EN
    sda = rv[3];
    scl_pos = 1'b1; cyc(); scl_pos = 1'b0;
    cyc();
    sda = ~rv[3];
    cyc();
    err_exp++;
    check("bus_error_pulse", {31'd0, bus_error}, 32'd1);
    check("bus_error_idle", {31'd0, rx_idle}, 32'd1);
    req_byte = 1'b0;
    cyc();
    check("bus_error_one_cycle", {31'd0, bus_error}, 32'd0);
    scl_neg = 1'b1; cyc(); scl_neg = 1'b0;
    cyc();
`else
    clock_bit(rv[3], 1'b1);
    for (int i = 5; i < 8; i++) clock_bit(rv[7-i], 1'b0);
    req_byte = 1'b0;
    cyc();
    exp_data = rv;
    done_exp++;
    check("unstable_sda_data", {24'd0, rx_data}, {24'd0, exp_data});
`endif
    cyc();
    check("stability_done_count", done_seen, done_exp);
    check("bus_error_count", err_seen, err_exp);
    check("final_idle", {31'd0, rx_idle}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
